// File: rtl/dcache_sa_if.sv
// rtl/dcache_sa_if.sv - CPU-side and memory-side handshake bundle for dcache_sa
interface dcache_sa_if #(
   parameter int ADDR_W = 32,
   parameter int LINE_W = 256
);
   logic [31:0]       p1_data_i;
   logic [ADDR_W-1:0] p1_addr_i;
   logic              p1_MemRead_i;
   logic              p1_MemWrite_i;
   logic [31:0]       p1_data_o;
   logic              p1_stall_o;
   logic [LINE_W-1:0] mem_data_i;
   logic              mem_ack_i;
   logic [LINE_W-1:0] mem_data_o;
   logic [ADDR_W-1:0] mem_addr_o;
   logic              mem_enable_o;
   logic              mem_write_o;

   // Cache side
   modport slave (
      input  p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
      output p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
   );

   // Pipeline and memory side
   modport master (
      output p1_data_i, p1_addr_i, p1_MemRead_i, p1_MemWrite_i, mem_data_i, mem_ack_i,
      input  p1_data_o, p1_stall_o, mem_data_o, mem_addr_o, mem_enable_o, mem_write_o
   );
endinterface

// File: rtl/dcache_sa.sv
// rtl/dcache_sa.sv - N-way set-associative write-back write-allocate data cache with true LRU
module dcache_sa #(
   parameter int SETS   = 16,
   parameter int WAYS   = 2,
   parameter int LINE_W = 256,
   parameter int ADDR_W = 32
) (
   input  logic        clk_i,
   input  logic        rst_i,
   dcache_sa_if.slave  bus,
   output logic [31:0] hit_count_o,
   output logic [31:0] miss_count_o
);
   localparam int OFF   = $clog2(LINE_W / 8);
   localparam int IDX   = $clog2(SETS);
   localparam int TAG   = ADDR_W - IDX - OFF;
   localparam int WSEL  = OFF - 2;
   localparam int WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
   localparam int AGE_W = WAY_W;

   typedef enum logic [1:0] {S_IDLE, S_WRITEBACK, S_GAP, S_ALLOCATE} state_t;

   state_t            state_q, state_d;
   logic [WAYS-1:0]   valid_q [SETS];
   logic [WAYS-1:0]   dirty_q [SETS];
   logic [TAG-1:0]    tag_q   [SETS][WAYS];
   logic [LINE_W-1:0] line_q  [SETS][WAYS];
   logic [AGE_W-1:0]  age_q   [SETS][WAYS];

   logic [WAY_W-1:0]  vway_q;
   logic [IDX-1:0]    vidx_q;
   logic [TAG-1:0]    vtag_q;
   logic [TAG-1:0]    rtag_q;
   logic [31:0]       hit_count_q, miss_count_q;

   logic              req, is_wr, hit, hit_any, miss_start, fill;
   logic [IDX-1:0]    idx;
   logic [TAG-1:0]    tag;
   logic [WSEL-1:0]   wsel;
   logic [WAY_W-1:0]  hit_way, vic_way;
   logic              vic_found, vic_dirty;
   logic              lru_en;
   logic [IDX-1:0]    lru_set;
   logic [WAY_W-1:0]  lru_way;
   logic              mem_enable, mem_write;
   logic [ADDR_W-1:0] mem_addr;
   logic [LINE_W-1:0] mem_data;
   logic              unused_addr;

   assign req   = bus.p1_MemRead_i | bus.p1_MemWrite_i;
   assign is_wr = bus.p1_MemWrite_i;
   assign idx   = bus.p1_addr_i[OFF +: IDX];
   assign tag   = bus.p1_addr_i[OFF + IDX +: TAG];
   assign wsel  = bus.p1_addr_i[2 +: WSEL];
   assign unused_addr = ^bus.p1_addr_i[1:0];

   // Tag compare across the ways of the addressed set
   always_comb begin
      hit_any = 1'b0;
      hit_way = '0;
      for (int w = 0; w < WAYS; w++) begin
         if (valid_q[idx][w] && (tag_q[idx][w] == tag)) begin
            hit_any = 1'b1;
            hit_way = WAY_W'(w);
         end
      end
   end

   assign hit            = req & (state_q == S_IDLE) & hit_any;
   assign bus.p1_stall_o = req & ((state_q != S_IDLE) | ~hit);
   assign bus.p1_data_o  = hit ? line_q[idx][hit_way][32 * wsel +: 32] : 32'd0;
   assign miss_start     = (state_q == S_IDLE) & req & ~hit_any;
   assign fill           = (state_q == S_ALLOCATE) & bus.mem_ack_i;

   // Victim: lowest-index invalid way, else the oldest way
   always_comb begin
      vic_way   = '0;
      vic_found = 1'b0;
      for (int w = 0; w < WAYS; w++) begin
         if (!vic_found && !valid_q[idx][w]) begin
            vic_found = 1'b1;
            vic_way   = WAY_W'(w);
         end
      end
      for (int w = 0; w < WAYS; w++) begin
         if (!vic_found && (age_q[idx][w] == AGE_W'(WAYS - 1))) begin
            vic_way = WAY_W'(w);
         end
      end
   end

   assign vic_dirty = valid_q[idx][vic_way] & dirty_q[idx][vic_way];

   // Select which set/way gets its age refreshed: a serviced hit or a completed fill
   always_comb begin
      lru_en  = 1'b0;
      lru_set = idx;
      lru_way = hit_way;
      if (hit) begin
         lru_en = 1'b1;
      end else if (fill) begin
         lru_en  = 1'b1;
         lru_set = vidx_q;
         lru_way = vway_q;
      end
   end

   generate
      if (WAYS > 1) begin : g_lru
         logic [AGE_W-1:0] age_new [WAYS];

         // Touched way becomes youngest; ways younger than it age by one
         always_comb begin
            for (int w = 0; w < WAYS; w++) begin
               if (WAY_W'(w) == lru_way) begin
                  age_new[w] = '0;
               end else if (age_q[lru_set][w] < age_q[lru_set][lru_way]) begin
                  age_new[w] = age_q[lru_set][w] + AGE_W'(1);
               end else begin
                  age_new[w] = age_q[lru_set][w];
               end
            end
         end

         // Ages restart as the way index so every set holds a permutation
         always_ff @(posedge clk_i) begin
            if (rst_i) begin
               for (int s = 0; s < SETS; s++) begin
                  for (int w = 0; w < WAYS; w++) begin
                     age_q[s][w] <= AGE_W'(w);
                  end
               end
            end else if (lru_en) begin
               for (int w = 0; w < WAYS; w++) begin
                  age_q[lru_set][w] <= age_new[w];
               end
            end
         end
      end else begin : g_no_lru
         for (genvar s = 0; s < SETS; s++) begin : g_set
            assign age_q[s][0] = '0;
         end
      end
   endgenerate

   // Valid/dirty bookkeeping; reset wins over a fill landing in the same cycle
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         for (int s = 0; s < SETS; s++) begin
            valid_q[s] <= '0;
            dirty_q[s] <= '0;
         end
      end else if (hit && is_wr) begin
         dirty_q[idx][hit_way] <= 1'b1;
      end else if (fill) begin
         valid_q[vidx_q][vway_q] <= 1'b1;
         dirty_q[vidx_q][vway_q] <= 1'b0;
      end
   end

   // Line and tag storage: store hits patch one word, fills replace the line
   always_ff @(posedge clk_i) begin
      if (hit && is_wr) begin
         line_q[idx][hit_way][32 * wsel +: 32] <= bus.p1_data_i;
      end else if (fill) begin
         line_q[vidx_q][vway_q] <= bus.mem_data_i;
         tag_q[vidx_q][vway_q]  <= rtag_q;
      end
   end

   // Capture the victim and the requested tag when a miss is first seen
   always_ff @(posedge clk_i) begin
      if (miss_start) begin
         vway_q <= vic_way;
         vidx_q <= idx;
         vtag_q <= tag_q[idx][vic_way];
         rtag_q <= tag;
      end
   end

   // Saturating hit and miss statistics
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         hit_count_q  <= '0;
         miss_count_q <= '0;
      end else begin
         if (hit && (hit_count_q != 32'hFFFF_FFFF)) hit_count_q <= hit_count_q + 32'd1;
         if (miss_start && (miss_count_q != 32'hFFFF_FFFF)) miss_count_q <= miss_count_q + 32'd1;
      end
   end

   assign hit_count_o  = hit_count_q;
   assign miss_count_o = miss_count_q;

   // FSM state register
   always_ff @(posedge clk_i) begin
      if (rst_i) state_q <= S_IDLE;
      else       state_q <= state_d;
   end

   // FSM next state; acks outside WRITEBACK/ALLOCATE are ignored
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:      if (miss_start) state_d = vic_dirty ? S_WRITEBACK : S_ALLOCATE;
         S_WRITEBACK: if (bus.mem_ack_i) state_d = S_GAP;
         S_GAP:       state_d = S_ALLOCATE;
         S_ALLOCATE:  if (bus.mem_ack_i) state_d = S_IDLE;
         default:     state_d = S_IDLE;
      endcase
   end

   // FSM outputs toward memory
   always_comb begin
      mem_enable = 1'b0;
      mem_write  = 1'b0;
      mem_addr   = '0;
      mem_data   = '0;
      case (state_q)
         S_WRITEBACK: begin
            mem_enable = 1'b1;
            mem_write  = 1'b1;
            mem_addr   = {vtag_q, vidx_q, {OFF{1'b0}}};
            mem_data   = line_q[vidx_q][vway_q];
         end
         S_ALLOCATE: begin
            mem_enable = 1'b1;
            mem_addr   = {rtag_q, vidx_q, {OFF{1'b0}}};
         end
         default: ;
      endcase
   end

   assign bus.mem_enable_o = mem_enable;
   assign bus.mem_write_o  = mem_write;
   assign bus.mem_addr_o   = mem_addr;
   assign bus.mem_data_o   = mem_data;
endmodule

// File: tb/tb_dcache_sa.sv
// tb/tb_dcache_sa.sv - self-checking bench for dcache_sa against a recency-list cache model
module tb_dcache_sa;
   localparam int SETS   = 16;
   localparam int WAYS   = 2;
   localparam int LINE_W = 256;
   localparam int ADDR_W = 32;
   localparam int TAGSH  = 5 + $clog2(SETS);

   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] hit_count, miss_count;
   int          checks = 0;
   int          failures = 0;

   dcache_sa_if #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) bus ();

   dcache_sa #(.SETS(SETS), .WAYS(WAYS), .LINE_W(LINE_W), .ADDR_W(ADDR_W)) u_dut (
      .clk_i        (clk),
      .rst_i        (rst),
      .bus          (bus.slave),
      .hit_count_o  (hit_count),
      .miss_count_o (miss_count)
   );

   always #5 clk = ~clk;

   // Backing memory: written lines kept, untouched lines follow a fixed pattern
   logic [LINE_W-1:0] bmem [int unsigned];

   function automatic logic [LINE_W-1:0] mem_line(input int unsigned a);
      logic [LINE_W-1:0] l;
      if (bmem.exists(a)) return bmem[a];
      for (int k = 0; k < 8; k++) l[k*32 +: 32] = a * 32'h9E37_79B1 + k * 32'h0100_0193;
      return l;
   endfunction

   // Reference model: per set, resident lines ordered most-recent first
   int unsigned       m_tag   [SETS][WAYS];
   bit                m_dirty [SETS][WAYS];
   logic [LINE_W-1:0] m_line  [SETS][WAYS];
   int                m_cnt   [SETS];
   int                m_hits, m_misses;
   bit                e_hit, e_wb;
   int unsigned       e_wb_addr, e_fill_addr;
   logic [LINE_W-1:0] e_wb_line;
   logic [31:0]       e_rdata;

   task automatic model_reset();
      for (int s = 0; s < SETS; s++) m_cnt[s] = 0;
      m_hits = 0;
      m_misses = 0;
   endtask

   task automatic model_access(input int unsigned addr, input bit wr, input logic [31:0] wdata);
      int unsigned set, tg, wd, t_tag;
      int pos;
      bit t_d;
      logic [LINE_W-1:0] t_l;
      set = (addr >> 5) % SETS;
      tg  = addr >> TAGSH;
      wd  = (addr >> 2) & 7;
      pos = -1;
      for (int i = 0; i < m_cnt[set]; i++) if (m_tag[set][i] == tg) pos = i;
      e_hit = (pos >= 0);
      e_wb = 0;
      e_fill_addr = addr & ~32'h1F;
      if (pos < 0) begin
         m_misses++;
         if (m_cnt[set] == WAYS) begin
            pos = WAYS - 1;
            if (m_dirty[set][pos]) begin
               e_wb = 1;
               e_wb_addr = (m_tag[set][pos] << TAGSH) | (set << 5);
               e_wb_line = m_line[set][pos];
            end
         end else begin
            pos = m_cnt[set];
            m_cnt[set]++;
         end
         t_tag = tg; t_d = 0; t_l = mem_line(e_fill_addr);
      end else begin
         t_tag = m_tag[set][pos]; t_d = m_dirty[set][pos]; t_l = m_line[set][pos];
      end
      for (int i = pos; i > 0; i--) begin
         m_tag[set][i] = m_tag[set][i-1];
         m_dirty[set][i] = m_dirty[set][i-1];
         m_line[set][i] = m_line[set][i-1];
      end
      m_tag[set][0] = t_tag; m_dirty[set][0] = t_d; m_line[set][0] = t_l;
      m_hits++;
      if (wr) begin
         m_line[set][0][wd*32 +: 32] = wdata;
         m_dirty[set][0] = 1;
      end
      e_rdata = m_line[set][0][wd*32 +: 32];
   endtask

   // Drives one CPU access (call at posedge+1) and plays the memory with ack in the lat-th enable cycle
   task automatic access(input logic [31:0] addr, input bit rd, input bit wr, input logic [31:0] wdata,
                         input int lat, output int n_stall, output logic [31:0] rdata,
                         output bit wb_seen, output logic [31:0] wb_addr, output logic [LINE_W-1:0] wb_line,
                         output bit fill_seen, output logic [31:0] fill_addr, output int n_gap,
                         output bit timeout);
      int en_cnt;
      n_stall = 0; n_gap = 0; wb_seen = 0; fill_seen = 0; wb_addr = 0; wb_line = 0;
      fill_addr = 0; rdata = 0; timeout = 1; en_cnt = 0;
      bus.p1_addr_i = addr; bus.p1_MemRead_i = rd; bus.p1_MemWrite_i = wr; bus.p1_data_i = wdata;
      for (int cyc = 0; cyc < 200; cyc++) begin
         @(negedge clk);
         bus.mem_ack_i = 1'b0;
         if (!bus.p1_stall_o) begin
            rdata = bus.p1_data_o;
            timeout = 0;
            break;
         end
         n_stall++;
         if (!bus.mem_enable_o) begin
            n_gap++;
         end else begin
            en_cnt++;
            if (en_cnt == lat) begin
               en_cnt = 0;
               bus.mem_ack_i = 1'b1;
               if (bus.mem_write_o) begin
                  wb_seen = 1; wb_addr = bus.mem_addr_o; wb_line = bus.mem_data_o;
                  bmem[bus.mem_addr_o] = bus.mem_data_o;
               end else begin
                  fill_seen = 1; fill_addr = bus.mem_addr_o;
                  bus.mem_data_i = mem_line(bus.mem_addr_o);
               end
            end
         end
      end
      @(posedge clk);
      #1;
      bus.p1_MemRead_i = 0; bus.p1_MemWrite_i = 0; bus.mem_ack_i = 0;
   endtask

   int                ns, ng;
   logic [31:0]       rd_d, wa, fa;
   logic [LINE_W-1:0] wl;
   bit                wbs, fs, to;

   task automatic test_reset();
      rst = 1;
      repeat (3) @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      checks++; if (bus.p1_stall_o !== 1'b0) begin failures++; $display("FAIL reset_stall got=%0h exp=0", bus.p1_stall_o); end
      checks++; if (bus.p1_data_o !== 32'd0) begin failures++; $display("FAIL reset_p1_data got=%0h exp=0", bus.p1_data_o); end
      checks++; if (bus.mem_enable_o !== 1'b0 || bus.mem_write_o !== 1'b0) begin failures++; $display("FAIL reset_mem_ctl got=%b%b exp=00", bus.mem_enable_o, bus.mem_write_o); end
      checks++; if (bus.mem_addr_o !== 32'd0 || bus.mem_data_o !== '0) begin failures++; $display("FAIL reset_mem_bus addr=%0h exp=0", bus.mem_addr_o); end
      checks++; if (hit_count !== 0 || miss_count !== 0) begin failures++; $display("FAIL reset_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
      @(posedge clk);
      #1;
   endtask

   task automatic test_clean_miss();
      logic [LINE_W-1:0] l;
      l = mem_line(32'h40);
      l[31:0] = 32'hDEAD_BEEF;
      bmem[32'h40] = l;
      model_access(32'h40, 0, 0);
      access(32'h40, 1, 0, 0, 10, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (to !== 1'b0) begin failures++; $display("FAIL clean_miss_timeout got=%0d exp=0", to); end
      checks++; if (!fs || fa !== 32'h40) begin failures++; $display("FAIL clean_miss_fill_addr got=%0h exp=40", fa); end
      checks++; if (wbs !== 1'b0) begin failures++; $display("FAIL clean_miss_wb got=%0d exp=0", wbs); end
      checks++; if (ns !== 11) begin failures++; $display("FAIL clean_miss_stall got=%0d exp=11", ns); end
      checks++; if (rd_d !== 32'hDEAD_BEEF) begin failures++; $display("FAIL clean_miss_data got=%0h exp=deadbeef", rd_d); end
      checks++; if (miss_count !== 1 || hit_count !== 1) begin failures++; $display("FAIL clean_miss_counters got=%0d/%0d exp=1/1", miss_count, hit_count); end
   endtask

   task automatic test_write_hit();
      model_access(32'h44, 1, 32'h1234_5678);
      access(32'h44, 0, 1, 32'h1234_5678, 3, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (ns !== 0 || to) begin failures++; $display("FAIL write_hit_stall got=%0d exp=0", ns); end
      model_access(32'h44, 0, 0);
      access(32'h44, 1, 0, 0, 3, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (rd_d !== 32'h1234_5678 || ns !== 0) begin failures++; $display("FAIL write_hit_readback got=%0h exp=12345678", rd_d); end
      checks++; if (hit_count !== 3) begin failures++; $display("FAIL write_hit_count got=%0d exp=3", hit_count); end
   endtask

   task automatic test_lru();
      logic [31:0] seq [4];
      seq = '{32'h1000, 32'h2000, 32'h1000, 32'h3000};
      foreach (seq[i]) begin
         model_access(seq[i], 0, 0);
         access(seq[i], 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      end
      checks++; if (ns !== 3 || wbs) begin failures++; $display("FAIL lru_c_miss stall=%0d exp=3", ns); end
      model_access(32'h1000, 0, 0);
      access(32'h1000, 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (ns !== 0 || rd_d !== e_rdata) begin failures++; $display("FAIL lru_a_hit stall=%0d data=%0h exp=0/%0h", ns, rd_d, e_rdata); end
      model_access(32'h2000, 0, 0);
      access(32'h2000, 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (ns !== 3) begin failures++; $display("FAIL lru_b_evicted stall=%0d exp=3", ns); end
   endtask

   task automatic test_dirty_evict();
      model_access(32'h240, 0, 0);
      access(32'h240, 1, 0, 0, 4, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (ns !== 5 || wbs) begin failures++; $display("FAIL dirty_first_miss stall=%0d exp=5", ns); end
      model_access(32'h440, 0, 0);
      access(32'h440, 1, 0, 0, 4, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (!wbs || wa !== 32'h40) begin failures++; $display("FAIL dirty_wb_addr got=%0h exp=40", wa); end
      checks++; if (wl[63:32] !== 32'h1234_5678) begin failures++; $display("FAIL dirty_wb_data got=%0h exp=12345678", wl[63:32]); end
      checks++; if (ns !== 10 || ng !== 2) begin failures++; $display("FAIL dirty_stall got=%0d gap=%0d exp=10/2", ns, ng); end
      checks++; if (fa !== 32'h440 || rd_d !== e_rdata) begin failures++; $display("FAIL dirty_fill got=%0h data=%0h exp=440/%0h", fa, rd_d, e_rdata); end
   endtask

   task automatic test_both_high();
      model_access(32'h448, 1, 32'hCAFE_F00D);
      access(32'h448, 1, 1, 32'hCAFE_F00D, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (ns !== 0 || to) begin failures++; $display("FAIL both_stall got=%0d exp=0", ns); end
      model_access(32'h448, 0, 0);
      access(32'h448, 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (rd_d !== 32'hCAFE_F00D) begin failures++; $display("FAIL both_readback got=%0h exp=cafef00d", rd_d); end
      model_access(32'h640, 0, 0);
      access(32'h640, 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (wbs) begin failures++; $display("FAIL both_clean_evict wb=%0d exp=0", wbs); end
      model_access(32'h840, 0, 0);
      access(32'h840, 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (!wbs || wa !== 32'h440 || wl[95:64] !== 32'hCAFE_F00D) begin failures++; $display("FAIL both_dirty_wb addr=%0h word=%0h exp=440/cafef00d", wa, wl[95:64]); end
   endtask

   task automatic test_reset_mid_miss();
      bit seen;
      seen = 0;
      bus.p1_addr_i = 32'hA0; bus.p1_MemRead_i = 1;
      for (int cyc = 0; cyc < 20; cyc++) begin
         @(negedge clk);
         if (bus.mem_enable_o && !bus.mem_write_o) begin seen = 1; break; end
      end
      checks++; if (!seen) begin failures++; $display("FAIL midrst_allocate got=0 exp=1"); end
      @(posedge clk);
      #1 rst = 1; bus.p1_MemRead_i = 0;
      @(posedge clk);
      #1 rst = 0;
      @(negedge clk);
      checks++; if (bus.mem_enable_o !== 1'b0) begin failures++; $display("FAIL midrst_enable got=%0h exp=0", bus.mem_enable_o); end
      checks++; if (hit_count !== 0 || miss_count !== 0) begin failures++; $display("FAIL midrst_counters got=%0d/%0d exp=0/0", hit_count, miss_count); end
      bus.mem_ack_i = 1; bus.mem_data_i = mem_line(32'hA0);
      @(posedge clk);
      #1 bus.mem_ack_i = 0;
      model_reset();
      model_access(32'hA0, 0, 0);
      access(32'hA0, 1, 0, 0, 2, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
      checks++; if (ns !== 3 || !fs || fa !== 32'hA0) begin failures++; $display("FAIL midrst_remiss stall=%0d fill=%0h exp=3/a0", ns, fa); end
      checks++; if (miss_count !== 1 || rd_d !== e_rdata) begin failures++; $display("FAIL midrst_after miss=%0d data=%0h exp=1/%0h", miss_count, rd_d, e_rdata); end
   endtask

   task automatic test_back_to_back_random();
      int unsigned a;
      int op, lat, exp_ns;
      for (int n = 0; n < 300; n++) begin
         a   = ($urandom_range(0, 3) << TAGSH) | ($urandom_range(0, 3) << 5) | ($urandom_range(0, 7) << 2);
         op  = $urandom_range(0, 2);
         lat = $urandom_range(1, 4);
         rd_d = $urandom;
         model_access(a, op != 0, rd_d);
         access(a, op != 1, op != 0, rd_d, lat, ns, rd_d, wbs, wa, wl, fs, fa, ng, to);
         exp_ns = e_hit ? 0 : (e_wb ? 2 * lat + 2 : lat + 1);
         checks++; if (to || ns !== exp_ns) begin failures++; $display("FAIL rand_stall addr=%0h got=%0d exp=%0d", a, ns, exp_ns); end
         checks++; if (wbs !== e_wb || (e_wb && (wa !== e_wb_addr || wl !== e_wb_line))) begin failures++; $display("FAIL rand_wb addr=%0h got=%0d/%0h exp=%0d/%0h", a, wbs, wa, e_wb, e_wb_addr); end
         checks++; if (!e_hit && fa !== e_fill_addr) begin failures++; $display("FAIL rand_fill addr=%0h got=%0h exp=%0h", a, fa, e_fill_addr); end
         if (op == 0) begin
            checks++; if (rd_d !== e_rdata) begin failures++; $display("FAIL rand_rdata addr=%0h got=%0h exp=%0h", a, rd_d, e_rdata); end
         end
      end
      checks++; if (hit_count !== m_hits || miss_count !== m_misses) begin failures++; $display("FAIL rand_counters got=%0d/%0d exp=%0d/%0d", hit_count, miss_count, m_hits, m_misses); end
   endtask

   initial begin
      rst = 1;
      bus.p1_data_i = 0; bus.p1_addr_i = 0; bus.p1_MemRead_i = 0; bus.p1_MemWrite_i = 0;
      bus.mem_data_i = '0; bus.mem_ack_i = 0;
      model_reset();
      test_reset();
      test_clean_miss();
      test_write_hit();
      test_lru();
      test_dirty_evict();
      test_both_high();
      test_reset_mid_miss();
      test_back_to_back_random();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/dcache_sa.md
# dcache_sa

Parametrised N-way set-associative, write-back, write-allocate data cache for the 5-stage pipeline. It replaces the direct-mapped data cache between the EX_MEM stage and the 256-bit data memory. It keeps the same CPU-side handshake (`p1_*`, stall-based) and memory-side handshake (`mem_*`, enable/ack). It adds configurable associativity with true-LRU replacement and hit/miss statistics counters.

## Interface
Parameters:
- `SETS`, default 16: number of sets. Power of two, ≥2.
- `WAYS`, default 2: associativity. Power of two, 1..8.
- `LINE_W`, default 256: line width in bits. Equals the memory data width.
- `ADDR_W`, default 32: byte address width.

Ports (reset is synchronous and active-high):
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  synchronous active-high reset.
- `p1_data_i`  in  32  store data.
- `p1_addr_i`  in  ADDR_W  byte address, word aligned.
- `p1_MemRead_i`  in  1  load request.
- `p1_MemWrite_i`  in  1  store request.
- `p1_data_o`  out  32  load data; valid when a read request is present and `p1_stall_o`=0.
- `p1_stall_o`  out  1  freezes the pipeline while a request is unserved.
- `mem_data_i`  in  LINE_W  fill data; valid in the `mem_ack_i` cycle.
- `mem_ack_i`  in  1  one-cycle completion pulse.
- `mem_data_o`  out  LINE_W  write-back line.
- `mem_addr_o`  out  ADDR_W  line address; low log2(LINE_W/8) bits are zero.
- `mem_enable_o`  out  1  transaction request; held until ack.
- `mem_write_o`  out  1  1 = write-back, 0 = fill.
- `hit_count_o`  out  32  saturating count of serviced hits.
- `miss_count_o`  out  32  saturating count of misses.

## Operation
Address split:
- OFF = log2(LINE_W/8), IDX = log2(SETS), TAG = ADDR_W−IDX−OFF.
- Word select = `addr[OFF-1:2]`.

Per-way, per-set state:
- valid, dirty, tag, line.
- LRU age of log2(WAYS) bits. Ages in a set always form a permutation of 0..WAYS−1.

Requests:
- Request = `p1_MemRead_i | p1_MemWrite_i`.
- If both are high, the request is treated as a write.
- Hit = request, state IDLE, and some valid way's tag matches. At most one way can match.

Read hit:
- `p1_data_o` returns the selected word combinationally.
- Stall stays 0.

Write hit:
- At the clock edge, the selected word is written, dirty is set to 1, and the LRU is updated.

LRU update on every hit or fill of way `w` with old age `a`:
- age[w] ← 0.
- Every way with age < `a` is incremented.

Victim selection:
- The lowest-index invalid way, if one exists.
- Otherwise the way with age WAYS−1.

FSM states: IDLE, WRITEBACK, GAP, ALLOCATE.
- IDLE, request, miss, victim dirty → WRITEBACK. Latch victim way and address; `miss_count_o`+1.
- IDLE, request, miss, victim clean or invalid → ALLOCATE. Latch victim way and address; `miss_count_o`+1.
- WRITEBACK: `mem_enable_o`=1, `mem_write_o`=1, `mem_addr_o`={victim tag, idx, 0}, `mem_data_o`=victim line. On `mem_ack_i` → GAP.
- GAP: `mem_enable_o`=0 for one cycle → ALLOCATE.
- ALLOCATE: `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`={req tag, idx, 0}. On `mem_ack_i`, write `mem_data_i` into the victim way: tag set, valid=1, dirty=0, LRU updated. Then → IDLE.
- Back in IDLE, the retried request hits. A store then writes and sets dirty (write-allocate).

Stall and counters:
- `p1_stall_o` = request & (state≠IDLE | ~hit).
- `hit_count_o` increments only on cycles where a request is present and stall=0.
- `mem_ack_i` is ignored in IDLE and GAP.
- The CPU must hold `p1_*` stable while stalled. Changes during a miss are unsupported.

## Timing
Reset values:
- FSM = IDLE.
- All valid and dirty = 0.
- age[w] = w in every set.
- Both counters = 0.
- `mem_enable_o`=0, `mem_write_o`=0, `mem_addr_o`=0, `mem_data_o`=0, `p1_data_o`=0.
- `p1_stall_o` follows its equation.

Reset mid-miss:
- The FSM returns to IDLE at the reset edge.
- `mem_enable_o` is 0 in the following cycle.
- A late ack is ignored.

Latency, with memory acking in the Lth cycle of enable:
- Hit: 0 stall cycles.
- Clean miss: stall high for 1+L cycles, then the hit cycle with stall 0.
- Dirty miss: stall high for 1+L+1+L cycles.

Other timing rules:
- Ack in the first enable cycle (L=1) is legal.
- Counters saturate at 0xFFFF_FFFF with no wrap.
- WAYS=1 degenerates to direct-mapped. LRU logic is absent and the victim is always way 0.

## Test plan
- Reset, then `lw` at 0x0000_0040 with memory returning a line whose word 0 = 0xDEAD_BEEF, L=10 → `mem_enable_o`=1, `mem_write_o`=0, `mem_addr_o`=0x40. Stall for 11 cycles, then `p1_data_o`=0xDEAD_BEEF with stall 0. `miss_count_o`=1, `hit_count_o`=1.
- `sw` 0x1234_5678 to 0x44 after the previous fill → no stall. A following `lw` 0x44 returns 0x1234_5678. `hit_count_o`=3.
- WAYS=2, SETS=16: access tags A, B, A, then C, all mapping to set 0 → C evicts B (the LRU way). A is still a hit afterwards.
- Dirty eviction: store to 0x40, then miss a third tag in set 2 twice → WRITEBACK with `mem_addr_o`=0x40 and `mem_data_o` containing 0x1234_5678. One cycle of `mem_enable_o`=0, then ALLOCATE. Total stall is 2L+2.
- Assert `rst_i` during ALLOCATE, then pulse `mem_ack_i` → no line installed. A re-read of the same address misses again. Counters are 0 after reset.
- Both `p1_MemRead_i` and `p1_MemWrite_i` high on a hit → treated as a store: the word is updated and dirty=1.
